// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared state type, 125 MHz default timing constants and helpers for button_debouncer
package btn_pkg;

  // Debounce FSM states.
  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_PRESS_PEND   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_PEND = 2'd3
  } btn_state_t;

  // Default timing at a 125 MHz system clock.
  localparam int DEF_DEBOUNCE_CYCLES     = 1_250_000;   // 10 ms
  localparam int DEF_REPEAT_DELAY_CYCLES = 62_500_000;  // 0.5 s
  localparam int DEF_REPEAT_RATE_CYCLES  = 25_000_000;  // 0.2 s

  // Larger of two ints, used to size the shared counter width.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/button_debouncer_if.sv
// rtl/button_debouncer_if.sv - raw button in, conditioned level/strobes/count out
interface button_debouncer_if;

  logic       btn_in;       // raw, asynchronous, bouncy
  logic       btn_level;    // debounced level, 1 = held
  logic       btn_press;    // one-cycle strobe per accepted press (and repeat)
  logic       btn_release;  // one-cycle strobe per accepted release
  logic [7:0] press_count;  // accepted press strobes, wraps 255->0

  // Side that drives the button and consumes the conditioned outputs.
  modport master (
    output btn_in,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  press_count
  );

  // The debouncer itself.
  modport slave (
    input  btn_in,
    output btn_level,
    output btn_press,
    output btn_release,
    output press_count
  );

endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 1-bit two-flop synchronizer with asynchronous reset to 0
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_q1_q, sync_q1_d;
  logic sync_q2_q, sync_q2_d;

  // Shift the asynchronous input through two stages.
  always_comb begin
    sync_q1_d = d;
    sync_q2_d = sync_q1_q;
  end

  // Synchronizer flops; the first stage may go metastable, the second settles it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q1_q <= 1'b0;
      sync_q2_q <= 1'b0;
    end else begin
      sync_q1_q <= sync_q1_d;
      sync_q2_q <= sync_q2_d;
    end
  end

  assign q = sync_q2_q;

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - synchronizer + counter-based debounce FSM; optional auto-repeat under BTN_AUTOREPEAT_EN
module button_debouncer
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BTN_AUTOREPEAT_EN
  ,
  parameter int REPEAT_DELAY_CYCLES = DEF_REPEAT_DELAY_CYCLES,
  parameter int REPEAT_RATE_CYCLES  = DEF_REPEAT_RATE_CYCLES
`endif
) (
  input  logic               clk,
  input  logic               rst,
  button_debouncer_if.slave  bus
);

`ifdef BTN_AUTOREPEAT_EN
  localparam int MAX_CYCLES = max_int(DEBOUNCE_CYCLES,
                                      max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES));
`else
  localparam int MAX_CYCLES = DEBOUNCE_CYCLES;
`endif
  localparam int CNT_W = $clog2(MAX_CYCLES);

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] RPT_DELAY_LAST = CNT_W'(REPEAT_DELAY_CYCLES - 1);
  localparam logic [CNT_W-1:0] RPT_RATE_LAST  = CNT_W'(REPEAT_RATE_CYCLES - 1);
`endif

  logic sync_q2;

  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             btn_level_q, btn_level_d;
  logic             btn_press_q, btn_press_d;
  logic             btn_release_q, btn_release_d;
  logic [7:0]       press_count_q, press_count_d;
`ifdef BTN_AUTOREPEAT_EN
  logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
  logic             rpt_first_q, rpt_first_d;  // still waiting for the initial delay
`endif

  sync_2ff u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.btn_in),
    .q   (sync_q2)
  );

  // Next-state logic: a pending edge is accepted only if the synchronized input
  // stays at the new level through the terminal-count edge; strobes default low.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    btn_level_d   = btn_level_q;
    btn_press_d   = 1'b0;
    btn_release_d = 1'b0;
    press_count_d = press_count_q;
`ifdef BTN_AUTOREPEAT_EN
    rpt_cnt_d     = rpt_cnt_q;
    rpt_first_d   = rpt_first_q;
`endif

    unique case (state_q)
      ST_RELEASED: begin
        if (sync_q2) begin
          state_d = ST_PRESS_PEND;
          cnt_d   = '0;
        end
      end

      ST_PRESS_PEND: begin
        if (!sync_q2) begin
          state_d = ST_RELEASED;
        end else if (cnt_q == DB_LAST) begin
          state_d       = ST_HELD;
          btn_level_d   = 1'b1;
          btn_press_d   = 1'b1;
          press_count_d = press_count_q + 8'd1;
`ifdef BTN_AUTOREPEAT_EN
          rpt_cnt_d     = '0;
          rpt_first_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_HELD: begin
        if (!sync_q2) begin
          state_d = ST_RELEASE_PEND;
          cnt_d   = '0;
        end
`ifdef BTN_AUTOREPEAT_EN
        // Repeat timing runs from HELD entry; it pauses (not restarts) while a
        // release is pending, so a short bounce does not reset the delay.
        else if (rpt_first_q) begin
          if (rpt_cnt_q == RPT_DELAY_LAST) begin
            btn_press_d   = 1'b1;
            press_count_d = press_count_q + 8'd1;
            rpt_cnt_d     = '0;
            rpt_first_d   = 1'b0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end else begin
          if (rpt_cnt_q == RPT_RATE_LAST) begin
            btn_press_d   = 1'b1;
            press_count_d = press_count_q + 8'd1;
            rpt_cnt_d     = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + 1'b1;
          end
        end
`endif
      end

      ST_RELEASE_PEND: begin
        if (sync_q2) begin
          state_d = ST_HELD;
        end else if (cnt_q == DB_LAST) begin
          state_d       = ST_RELEASED;
          btn_level_d   = 1'b0;
          btn_release_d = 1'b1;
`ifdef BTN_AUTOREPEAT_EN
          rpt_cnt_d     = '0;
          rpt_first_d   = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = ST_RELEASED;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counters and registered outputs; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_RELEASED;
      cnt_q         <= '0;
      btn_level_q   <= 1'b0;
      btn_press_q   <= 1'b0;
      btn_release_q <= 1'b0;
      press_count_q <= 8'd0;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q     <= '0;
      rpt_first_q   <= 1'b1;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      btn_level_q   <= btn_level_d;
      btn_press_q   <= btn_press_d;
      btn_release_q <= btn_release_d;
      press_count_q <= press_count_d;
`ifdef BTN_AUTOREPEAT_EN
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_first_q   <= rpt_first_d;
`endif
    end
  end

  assign bus.btn_level   = btn_level_q;
  assign bus.btn_press   = btn_press_q;
  assign bus.btn_release = btn_release_q;
  assign bus.press_count = press_count_q;

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer (BTN_AUTOREPEAT_EN adds the repeat test)
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int n_cmp = 0;
  int n_err = 0;

  int press_seen = 0;
  int rel_seen   = 0;
  int both_seen  = 0;

  button_debouncer_if bif ();

`ifdef BTN_AUTOREPEAT_EN
  button_debouncer #(
    .DEBOUNCE_CYCLES     (4),
    .REPEAT_DELAY_CYCLES (10),
    .REPEAT_RATE_CYCLES  (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );
`else
  button_debouncer #(
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bif)
  );
`endif

  always #5 clk = ~clk;

  // Strobe monitor sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (bif.btn_press)   press_seen = press_seen + 1;
      if (bif.btn_release) rel_seen   = rel_seen + 1;
      if (bif.btn_press && bif.btn_release) both_seen = both_seen + 1;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int p0, r0;

  initial begin
    bif.btn_in = 1'b0;
    tick(2);
    chk("rst_level",   int'(bif.btn_level),   0);
    chk("rst_press",   int'(bif.btn_press),   0);
    chk("rst_release", int'(bif.btn_release), 0);
    chk("rst_count",   int'(bif.press_count), 0);
    rst = 1'b0;
    tick(2);

    // 1: clean press; first sampled at edge k, press after edge k+6.
    p0 = press_seen;
    bif.btn_in = 1'b1;
    tick(6);
    chk("t1_press_early", int'(bif.btn_press), 0);
    chk("t1_level_early", int'(bif.btn_level), 0);
    tick(1);
    chk("t1_press",       int'(bif.btn_press), 1);
    chk("t1_level",       int'(bif.btn_level), 1);
    chk("t1_count",       int'(bif.press_count), 1);
    tick(1);
    chk("t1_press_1cyc",  int'(bif.btn_press), 0);
    chk("t1_level_hold",  int'(bif.btn_level), 1);
    tick(12);
    chk("t1_one_press",   press_seen - p0, 1);
    r0 = rel_seen;
    bif.btn_in = 1'b0;
    tick(7);
    chk("t1_release",     int'(bif.btn_release), 1);
    chk("t1_rel_level",   int'(bif.btn_level), 0);
    tick(3);
    chk("t1_one_release", rel_seen - r0, 1);

    // 2: bounce 1,0,1,0 then stable 1.
    p0 = press_seen;
    bif.btn_in = 1'b1; tick(1);
    bif.btn_in = 1'b0; tick(1);
    bif.btn_in = 1'b1; tick(1);
    bif.btn_in = 1'b0; tick(1);
    bif.btn_in = 1'b1;
    tick(3);
    chk("t2_no_strobe",   press_seen - p0, 0);
    tick(10);
    chk("t2_one_press",   press_seen - p0, 1);
    chk("t2_count",       int'(bif.press_count), 2);

    // 3: 2-clk low glitch from HELD, then clean release.
    r0 = rel_seen;
    bif.btn_in = 1'b0; tick(2);
    bif.btn_in = 1'b1;
    tick(10);
    chk("t3_no_release",  rel_seen - r0, 0);
    chk("t3_level_kept",  int'(bif.btn_level), 1);
    bif.btn_in = 1'b0;
    tick(6);
    chk("t3_rel_early",   int'(bif.btn_release), 0);
    tick(1);
    chk("t3_release",     int'(bif.btn_release), 1);
    chk("t3_level_low",   int'(bif.btn_level), 0);
    tick(3);
    chk("t3_one_release", rel_seen - r0, 1);

    // 4: reset while PRESS_PEND at cnt=3, button held through deassert.
    bif.btn_in = 1'b1;
    tick(6);
    rst = 1'b1;
    #2;
    chk("t4_rst_count",   int'(bif.press_count), 0);
    chk("t4_rst_level",   int'(bif.btn_level), 0);
    chk("t4_rst_press",   int'(bif.btn_press), 0);
    tick(1);
    rst = 1'b0;
    tick(6);
    chk("t4_press_early", int'(bif.btn_press), 0);
    tick(1);
    chk("t4_press",       int'(bif.btn_press), 1);
    chk("t4_count",       int'(bif.press_count), 1);
    bif.btn_in = 1'b0;
    tick(10);

    // 5: 256 clean presses from reset; count wraps to 0.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    p0 = press_seen;
    for (int i = 0; i < 256; i++) begin
      bif.btn_in = 1'b1; tick(9);
      bif.btn_in = 1'b0; tick(9);
      if (i == 254) chk("t5_count_255", int'(bif.press_count), 255);
    end
    chk("t5_wrap",        int'(bif.press_count), 0);
    chk("t5_presses",     press_seen - p0, 256);
    chk("t5_no_overlap",  both_seen, 0);

`ifdef BTN_AUTOREPEAT_EN
    // 6: auto-repeat; strobes at +0, +10, +15, +20, +25, +30 after accept.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);
    bif.btn_in = 1'b1;
    tick(7);
    chk("t6_accept",      int'(bif.btn_press), 1);
    for (int j = 1; j <= 30; j++) begin
      tick(1);
      chk($sformatf("t6_rpt_%0d", j), int'(bif.btn_press),
          (j == 10 || j == 15 || j == 20 || j == 25 || j == 30) ? 1 : 0);
    end
    chk("t6_count",       int'(bif.press_count), 6);
    chk("t6_level",       int'(bif.btn_level), 1);
    bif.btn_in = 1'b0;
    tick(10);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
